lc3_datapath_mem: RTL and testbench

Width-parametrised LC-3 datapath with an integrated memory-handshake engine, a condition-code/branch-enable unit and bus-conflict detection. It sits between the control FSM and the memory subsystem. It owns PC, IR, MAR, MDR, the 8-entry register file, the ALU and the shared bus. Whenever a memory access is outstanding it stalls the controller, and it aborts any access that exceeds a programmable timeout.

---
 rtl/lc3_datapath_mem.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lc3_datapath_mem.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_datapath_mem.sv
// LC-3 datapath: PC/IR/MAR/MDR, register file, ALU, shared bus, condition codes,
// branch enable, and a memory handshake engine that stalls the controller.
module lc3_datapath_mem #(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned      MEM_TIMEOUT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             GateMARMUX,
    input  logic             GatePC,
    input  logic             GateALU,
    input  logic             GateMDR,
    input  logic             LD_REG,
    input  logic             LD_BEN,
    input  logic             LD_CC,
    input  logic             LD_IR,
    input  logic             LD_MAR,
    input  logic             LD_MDR,
    input  logic             LD_PC,
    input  logic             MIO_EN,
    input  logic             MEM_WE,
    input  logic             MARMUX,
    input  logic             ADDR1MUX,
    input  logic             SR2MUX,
    input  logic [1:0]       PCMUX,
    input  logic [1:0]       DRMUX,
    input  logic [1:0]       SR1MUX,
    input  logic [1:0]       ADDR2MUX,
    input  logic [1:0]       ALUK,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             stall,
    output logic             BEN,
    output logic [WIDTH-1:0] IR_out,
    output logic [WIDTH-1:0] PC_out,
    output logic [WIDTH-1:0] MAR_out,
    output logic [WIDTH-1:0] MDR_out,
    output logic             mem_err,
    output logic             bus_conflict
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } mem_state_t;

    mem_state_t       state;
    logic             done;
    logic [CNT_W-1:0] wait_cnt;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] ir;
    logic [WIDTH-1:0] mar;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] regs [8];
    logic [2:0]       cc;

    logic [WIDTH-1:0] sext5;
    logic [WIDTH-1:0] sext6;
    logic [WIDTH-1:0] sext9;
    logic [WIDTH-1:0] sext11;
    logic [WIDTH-1:0] zext8;
    logic [2:0]       dr;
    logic [2:0]       sr1;
    logic [WIDTH-1:0] sr1_val;
    logic [WIDTH-1:0] sr2_val;
    logic [WIDTH-1:0] addr1;
    logic [WIDTH-1:0] addr2;
    logic [WIDTH-1:0] adder;
    logic [WIDTH-1:0] marmux_val;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] bus;
    logic [3:0]       gates;
    logic             multi_gate;
    logic             start_rd;
    logic             start_wr;
    logic             busy;
    logic             run;
    logic             timeout;
    logic [2:0]       bus_cc;

    // IR field extraction
    assign sext5  = {{(WIDTH-5){ir[4]}}, ir[4:0]};
    assign sext6  = {{(WIDTH-6){ir[5]}}, ir[5:0]};
    assign sext9  = {{(WIDTH-9){ir[8]}}, ir[8:0]};
    assign sext11 = {{(WIDTH-11){ir[10]}}, ir[10:0]};
    assign zext8  = {{(WIDTH-8){1'b0}}, ir[7:0]};

    always_comb begin
        dr  = ir[11:9];
        sr1 = ir[11:9];
        case (DRMUX)
            2'd1:    dr = 3'd7;
            2'd2:    dr = 3'd6;
            default: dr = ir[11:9];
        endcase
        case (SR1MUX)
            2'd1, 2'd3: sr1 = ir[8:6];
            2'd2:       sr1 = 3'd6;
            default:    sr1 = ir[11:9];
        endcase
    end

    assign sr1_val = regs[sr1];
    assign sr2_val = regs[ir[2:0]];

    // Address adder and MARMUX
    always_comb begin
        addr1 = ADDR1MUX ? sr1_val : pc;
        addr2 = '0;
        case (ADDR2MUX)
            2'd1:    addr2 = sext6;
            2'd2:    addr2 = sext9;
            2'd3:    addr2 = sext11;
            default: addr2 = '0;
        endcase
    end

    assign adder      = addr1 + addr2;
    assign marmux_val = MARMUX ? adder : zext8;

    always_comb begin
        alu_b = SR2MUX ? sext5 : sr2_val;
        alu   = sr1_val;
        case (ALUK)
            2'd0:    alu = sr1_val + alu_b;
            2'd1:    alu = sr1_val & alu_b;
            2'd2:    alu = ~sr1_val;
            default: alu = sr1_val;
        endcase
    end

    always_comb begin
        pc_next = pc;
        case (PCMUX)
            2'd0:    pc_next = pc + WIDTH'(1);
            2'd1:    pc_next = bus;
            2'd2:    pc_next = adder;
            default: pc_next = pc;
        endcase
    end

    // Shared bus: only a single asserted gate drives it, otherwise it reads zero
    assign gates      = {GateMARMUX, GatePC, GateALU, GateMDR};
    assign multi_gate = (gates & (gates - 4'd1)) != 4'd0;

    always_comb begin
        bus = '0;
        case (gates)
            4'b1000: bus = marmux_val;
            4'b0100: bus = pc;
            4'b0010: bus = alu;
            4'b0001: bus = mdr;
            default: bus = '0;
        endcase
    end

    assign bus_cc[2] = bus[WIDTH-1];
    assign bus_cc[1] = (bus == '0);
    assign bus_cc[0] = !bus[WIDTH-1] && (bus != '0);

    // Memory handshake control
    assign start_rd = LD_MDR && MIO_EN && !done;
    assign start_wr = MEM_WE && !done && !start_rd;
    assign busy     = (state != S_IDLE);
    assign stall    = busy || start_rd || start_wr;
    assign run      = !stall;
    assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            done     <= 1'b0;
            wait_cnt <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mdr      <= '0;
            mem_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (start_rd) begin
                        state    <= S_READ;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        wait_cnt <= CNT_W'(1);
                    end else if (start_wr) begin
                        state    <= S_WRITE;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        wait_cnt <= CNT_W'(1);
                    end else if (LD_MDR && !MIO_EN) begin
                        mdr <= bus;
                    end
                end
                S_READ, S_WRITE: begin
                    // An ack arriving in the timeout cycle still completes normally
                    if (mem_ack || timeout) begin
                        if (state == S_READ) begin
                            mdr <= mem_ack ? mem_rdata : '1;
                        end
                        if (!mem_ack) begin
                            mem_err <= 1'b1;
                        end
                        state    <= S_IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        done     <= 1'b1;
                        wait_cnt <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Architectural registers; loads are frozen while the controller is stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            ir           <= '0;
            mar          <= '0;
            cc           <= 3'b010;
            BEN          <= 1'b0;
            bus_conflict <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (multi_gate) begin
                bus_conflict <= 1'b1;
            end
            if (run) begin
                if (LD_PC) begin
                    pc <= pc_next;
                end
                if (LD_IR) begin
                    ir <= bus;
                end
                if (LD_MAR) begin
                    mar <= bus;
                end
                if (LD_REG) begin
                    regs[dr] <= bus;
                end
                if (LD_CC) begin
                    cc <= bus_cc;
                end
                if (LD_BEN) begin
                    BEN <= |(ir[11:9] & cc);
                end
            end
        end
    end

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign IR_out    = ir;
    assign PC_out    = pc;
    assign MAR_out   = mar;
    assign MDR_out   = mdr;

endmodule

// File: tb/tb_lc3_datapath_mem.sv
// Directed bench for lc3_datapath_mem: a 16-bit instance with a 4-cycle timeout
// and a 32-bit instance sharing the same control inputs.
module tb_lc3_datapath_mem;

    logic clk;
    logic reset;
    logic GateMARMUX, GatePC, GateALU, GateMDR;
    logic LD_REG, LD_BEN, LD_CC, LD_IR, LD_MAR, LD_MDR, LD_PC;
    logic MIO_EN, MEM_WE, MARMUX, ADDR1MUX, SR2MUX;
    logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
    logic mem_ack;

    logic [15:0] rdata_a, addr_a, wdata_a, ir_a, pc_a, mar_a, mdr_a;
    logic        req_a, we_a, stall_a, ben_a, err_a, conf_a;
    logic [31:0] rdata_b, addr_b, wdata_b, ir_b, pc_b, mar_b, mdr_b;
    logic        req_b, we_b, stall_b, ben_b, err_b, conf_b;

    int n_checks = 0;
    int n_fail   = 0;

    lc3_datapath_mem #(.WIDTH(16), .RESET_PC(16'h3000), .MEM_TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset),
        .GateMARMUX(GateMARMUX), .GatePC(GatePC), .GateALU(GateALU), .GateMDR(GateMDR),
        .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_PC(LD_PC),
        .MIO_EN(MIO_EN), .MEM_WE(MEM_WE), .MARMUX(MARMUX), .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
        .mem_req(req_a), .mem_we(we_a), .mem_ack(mem_ack), .stall(stall_a), .BEN(ben_a),
        .IR_out(ir_a), .PC_out(pc_a), .MAR_out(mar_a), .MDR_out(mdr_a),
        .mem_err(err_a), .bus_conflict(conf_a)
    );

    lc3_datapath_mem #(.WIDTH(32), .RESET_PC(32'h0000_0010), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset),
        .GateMARMUX(GateMARMUX), .GatePC(GatePC), .GateALU(GateALU), .GateMDR(GateMDR),
        .LD_REG(LD_REG), .LD_BEN(LD_BEN), .LD_CC(LD_CC), .LD_IR(LD_IR),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_PC(LD_PC),
        .MIO_EN(MIO_EN), .MEM_WE(MEM_WE), .MARMUX(MARMUX), .ADDR1MUX(ADDR1MUX), .SR2MUX(SR2MUX),
        .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
        .mem_req(req_b), .mem_we(we_b), .mem_ack(mem_ack), .stall(stall_b), .BEN(ben_b),
        .IR_out(ir_b), .PC_out(pc_b), .MAR_out(mar_b), .MDR_out(mdr_b),
        .mem_err(err_b), .bus_conflict(conf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task clr_ctl();
        GateMARMUX = 0; GatePC = 0; GateALU = 0; GateMDR = 0;
        LD_REG = 0; LD_BEN = 0; LD_CC = 0; LD_IR = 0; LD_MAR = 0; LD_MDR = 0; LD_PC = 0;
        MIO_EN = 0; MEM_WE = 0; MARMUX = 0; ADDR1MUX = 0; SR2MUX = 0;
        PCMUX = 2'd0; DRMUX = 2'd0; SR1MUX = 2'd0; ADDR2MUX = 2'd0; ALUK = 2'd0;
        mem_ack = 0;
    endtask

    task step();
        @(posedge clk);
        #1;
    endtask

    task settle();
        @(negedge clk);
    endtask

    // Two-cycle read with immediate ack; leaves the bench one cycle past completion
    task mem_read(input logic [15:0] d16, input logic [31:0] d32);
        LD_MDR = 1; MIO_EN = 1;
        step();
        mem_ack = 1; rdata_a = d16; rdata_b = d32;
        step();
        clr_ctl();
        step();
    endtask

    task load_ir_from_mdr();
        GateMDR = 1; LD_IR = 1;
        step();
        clr_ctl();
    endtask

    task test_reset();
        clr_ctl();
        reset = 1;
        step();
        settle();
        n_checks++;
        if (pc_a !== 16'h3000) begin n_fail++; $display("FAIL reset_pc: got %h expected 3000", pc_a); end
        n_checks++;
        if ({ir_a, mar_a, mdr_a} !== 48'h0) begin
            n_fail++; $display("FAIL reset_regs: got ir=%h mar=%h mdr=%h expected all 0", ir_a, mar_a, mdr_a);
        end
        n_checks++;
        if ({req_a, we_a, stall_a, ben_a, err_a, conf_a} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000000", {req_a, we_a, stall_a, ben_a, err_a, conf_a});
        end
        n_checks++;
        if (pc_b !== 32'h10) begin n_fail++; $display("FAIL reset_pc32: got %h expected 00000010", pc_b); end
        step();
        reset = 0;
        // start a read, then reset in the middle of it
        LD_MDR = 1; MIO_EN = 1;
        step();
        settle();
        n_checks++;
        if (req_a !== 1'b1) begin n_fail++; $display("FAIL pre_reset_req: got %b expected 1", req_a); end
        clr_ctl();
        reset = 1;
        #1;
        n_checks++;
        if (req_a !== 1'b0 || stall_a !== 1'b0) begin
            n_fail++; $display("FAIL async_reset_req: got req=%b stall=%b expected 0 0", req_a, stall_a);
        end
        n_checks++;
        if (pc_a !== 16'h3000) begin n_fail++; $display("FAIL async_reset_pc: got %h expected 3000", pc_a); end
        step();
        reset = 0;
        // CC is Z after reset: IR[11:9]=010 gives BEN=1
        mem_read(16'h0400, 32'h0000_0400);
        load_ir_from_mdr();
        LD_BEN = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (ben_a !== 1'b1) begin n_fail++; $display("FAIL reset_cc_z: got BEN=%b expected 1", ben_a); end
        step();
    endtask

    task test_alu_cc();
        mem_read(16'h1261, 32'h0000_1261);
        load_ir_from_mdr();
        settle();
        n_checks++;
        if (ir_a !== 16'h1261) begin n_fail++; $display("FAIL ir_load: got %h expected 1261", ir_a); end
        step();
        // CC still Z, IR[11:9]=001 -> BEN=0
        LD_BEN = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (ben_a !== 1'b0) begin n_fail++; $display("FAIL ben_z_vs_p: got %b expected 0", ben_a); end
        step();
        mem_read(16'h0005, 32'h0000_0005);
        GateMDR = 1; LD_REG = 1; DRMUX = 2'd0;
        step();
        clr_ctl();
        // ADD R1,R1,#1
        SR1MUX = 2'd1; SR2MUX = 1; ALUK = 2'd0; GateALU = 1; LD_REG = 1; LD_CC = 1; DRMUX = 2'd0;
        step();
        clr_ctl();
        LD_BEN = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (ben_a !== 1'b1) begin n_fail++; $display("FAIL ben_after_add: got %b expected 1", ben_a); end
        step();
        SR1MUX = 2'd1; ALUK = 2'd3; GateALU = 1; LD_MAR = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (mar_a !== 16'h0006) begin n_fail++; $display("FAIL add_result_r1: got %h expected 0006", mar_a); end
        step();
        GateMARMUX = 1; MARMUX = 0; LD_MAR = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (mar_a !== 16'h0061) begin n_fail++; $display("FAIL marmux_zext8: got %h expected 0061", mar_a); end
        step();
        LD_PC = 1; PCMUX = 2'd0;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (pc_a !== 16'h3001) begin n_fail++; $display("FAIL pc_incr: got %h expected 3001", pc_a); end
        step();
        // PC + sext(IR[5:0]) with IR[5:0]=100001 (-31)
        LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 0; ADDR2MUX = 2'd1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (pc_a !== 16'h2FE2) begin n_fail++; $display("FAIL pc_adder_sext6: got %h expected 2fe2", pc_a); end
        step();
    endtask

    task test_mem_read();
        mem_read(16'h4000, 32'h0000_4000);
        GateMDR = 1; LD_MAR = 1;
        step();
        clr_ctl();
        LD_MDR = 1; MIO_EN = 1; rdata_a = 16'hBEEF;
        settle();
        n_checks++;
        if ({stall_a, req_a} !== 2'b10) begin n_fail++; $display("FAIL rd_cycle0: got stall,req=%b expected 10", {stall_a, req_a}); end
        step();
        settle();
        n_checks++;
        if ({stall_a, req_a, we_a} !== 3'b110 || addr_a !== 16'h4000) begin
            n_fail++; $display("FAIL rd_cycle1: got stall,req,we=%b addr=%h expected 110 4000", {stall_a, req_a, we_a}, addr_a);
        end
        step();
        settle();
        n_checks++;
        if (stall_a !== 1'b1) begin n_fail++; $display("FAIL rd_cycle2_stall: got %b expected 1", stall_a); end
        step();
        mem_ack = 1;
        settle();
        n_checks++;
        if (stall_a !== 1'b1 || mdr_a !== 16'h4000) begin
            n_fail++; $display("FAIL rd_ack_cycle: got stall=%b mdr=%h expected 1 4000", stall_a, mdr_a);
        end
        step();
        mem_ack = 0;
        settle();
        n_checks++;
        if ({stall_a, req_a} !== 2'b00 || mdr_a !== 16'hBEEF) begin
            n_fail++; $display("FAIL rd_complete: got stall,req=%b mdr=%h expected 00 beef", {stall_a, req_a}, mdr_a);
        end
        clr_ctl();
        step();
        settle();
        n_checks++;
        if (req_a !== 1'b0) begin n_fail++; $display("FAIL rd_single_request: got req=%b expected 0", req_a); end
        step();
    endtask

    task test_write_timeout();
        MEM_WE = 1;
        settle();
        n_checks++;
        if ({stall_a, req_a, err_a} !== 3'b100) begin
            n_fail++; $display("FAIL wr_cycle0: got stall,req,err=%b expected 100", {stall_a, req_a, err_a});
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            settle();
            n_checks++;
            if ({req_a, we_a, stall_a} !== 3'b111 || wdata_a !== 16'hBEEF) begin
                n_fail++; $display("FAIL wr_wait_%0d: got req,we,stall=%b wdata=%h expected 111 beef", i, {req_a, we_a, stall_a}, wdata_a);
            end
        end
        step();
        settle();
        n_checks++;
        if ({req_a, stall_a, err_a} !== 3'b001) begin
            n_fail++; $display("FAIL wr_timeout: got req,stall,err=%b expected 001", {req_a, stall_a, err_a});
        end
        clr_ctl();
        step();
        LD_MDR = 1; MIO_EN = 1;
        repeat (5) step();
        settle();
        n_checks++;
        if (mdr_a !== 16'hFFFF || stall_a !== 1'b0 || err_a !== 1'b1) begin
            n_fail++; $display("FAIL rd_timeout: got mdr=%h stall=%b err=%b expected ffff 0 1", mdr_a, stall_a, err_a);
        end
        clr_ctl();
        step();
    endtask

    task test_bus_conflict();
        settle();
        n_checks++;
        if (conf_a !== 1'b0) begin n_fail++; $display("FAIL conflict_clear: got %b expected 0", conf_a); end
        step();
        GatePC = 1; GateALU = 1; LD_MAR = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (mar_a !== 16'h0000 || conf_a !== 1'b1) begin
            n_fail++; $display("FAIL conflict_set: got mar=%h conflict=%b expected 0000 1", mar_a, conf_a);
        end
        repeat (3) step();
        settle();
        n_checks++;
        if (conf_a !== 1'b1) begin n_fail++; $display("FAIL conflict_sticky: got %b expected 1", conf_a); end
        reset = 1;
        #1;
        n_checks++;
        if (conf_a !== 1'b0 || err_a !== 1'b0) begin
            n_fail++; $display("FAIL sticky_reset: got conflict=%b err=%b expected 0 0", conf_a, err_a);
        end
        step();
        reset = 0;
    endtask

    task test_width32();
        mem_read(16'h0400, 32'h0000_0400);
        load_ir_from_mdr();
        GateMARMUX = 1; MARMUX = 1; ADDR1MUX = 0; ADDR2MUX = 2'd3; LD_MAR = 1;
        step();
        clr_ctl();
        settle();
        n_checks++;
        if (ir_b !== 32'h0000_0400) begin n_fail++; $display("FAIL ir32: got %h expected 00000400", ir_b); end
        n_checks++;
        if (mar_b !== 32'hFFFF_FC10 || addr_b !== 32'hFFFF_FC10) begin
            n_fail++; $display("FAIL marmux_sext11_32: got mar=%h addr=%h expected fffffc10", mar_b, addr_b);
        end
        n_checks++;
        if (mar_a !== 16'h2C00) begin n_fail++; $display("FAIL marmux_sext11_16: got %h expected 2c00", mar_a); end
        step();
    endtask

    initial begin
        rdata_a = '0;
        rdata_b = '0;
        reset   = 1;
        clr_ctl();
        test_reset();
        test_alu_cc();
        test_mem_read();
        test_write_timeout();
        test_bus_conflict();
        test_width32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
